// File: rtl/fetch_ooo.sv
// Instruction fetch with tagged, out-of-order memory completion and in-order delivery
// to decode; decode redirects flush buffered fetches and mark outstanding ones stale.
module fetch_ooo #(
  parameter int                     p_addr_bits     = 32,
  parameter logic [p_addr_bits-1:0] p_rst_addr      = '0,
  parameter int                     p_inst_bits     = 32,
  parameter int                     p_opaq_bits     = 8,
  parameter int                     p_max_in_flight = 4,
  parameter int                     p_seq_bits      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic [p_addr_bits-1:0] mem_req_addr,
  output logic [p_opaq_bits-1:0] mem_req_opaque,
  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  input  logic [p_opaq_bits-1:0] mem_resp_opaque,
  input  logic [p_inst_bits-1:0] mem_resp_data,
  output logic                   D_val,
  input  logic                   D_rdy,
  output logic [p_inst_bits-1:0] D_inst,
  output logic [p_addr_bits-1:0] D_pc,
  output logic [p_seq_bits-1:0]  D_seq_num,
  input  logic                   D_br_val,
  input  logic [p_addr_bits-1:0] D_br_target
);
  localparam int N  = p_max_in_flight;
  localparam int IW = $clog2(p_max_in_flight);
  localparam logic [N-1:0] SLOT0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [p_addr_bits-1:0] PC_STEP = p_addr_bits'(4);

  logic [N-1:0]           r_busy;
  logic [N-1:0]           r_ready;
  logic [N-1:0]           r_stale;
  logic [p_addr_bits-1:0] r_slot_pc   [N];
  logic [p_inst_bits-1:0] r_slot_inst [N];
  logic [p_addr_bits-1:0] r_pc;
  logic [IW-1:0]          r_head;
  logic [IW-1:0]          r_tail;
  logic [p_seq_bits-1:0]  r_seq;

  logic          w_req_fire;
  logic          w_resp_fire;
  logic          w_resp_hit;
  logic          w_d_fire;
  logic [IW-1:0] w_resp_idx;
  logic [IW-1:0] w_tail_nxt;
  logic [N-1:0]  w_iss_oh;
  logic [N-1:0]  w_resp_oh;
  logic [N-1:0]  w_dlv_oh;

  // Valid/ready: a transfer happens on a posedge where val && rdy; no val here
  // depends combinationally on its own rdy.
  assign mem_req_val  = !rst && !r_busy[r_tail];
  assign mem_req_addr = r_pc;
  assign mem_resp_rdy = !rst;

  always_comb begin
    mem_req_opaque = '0;
    mem_req_opaque[IW-1:0] = r_tail;
  end

  assign D_val     = r_busy[r_head] && r_ready[r_head] && !r_stale[r_head];
  assign D_inst    = r_slot_inst[r_head];
  assign D_pc      = r_slot_pc[r_head];
  assign D_seq_num = r_seq;

  assign w_req_fire  = mem_req_val && mem_req_rdy;
  assign w_resp_fire = mem_resp_val && mem_resp_rdy;
  assign w_d_fire    = D_val && D_rdy;
  assign w_resp_idx  = mem_resp_opaque[IW-1:0];
  // Tags with bits set above the slot index name no slot and are ignored.
  assign w_resp_hit  = w_resp_fire && ((mem_resp_opaque >> IW) == '0);
  assign w_tail_nxt  = w_req_fire ? r_tail + IW'(1) : r_tail;

  assign w_iss_oh  = w_req_fire ? (SLOT0 << r_tail)     : '0;
  assign w_resp_oh = w_resp_hit ? (SLOT0 << w_resp_idx) : '0;
  assign w_dlv_oh  = w_d_fire   ? (SLOT0 << r_head)     : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= '0;
      r_ready <= '0;
      r_stale <= '0;
      r_pc    <= p_rst_addr;
      r_head  <= '0;
      r_tail  <= '0;
      r_seq   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_iss_oh[i]) begin
          // A request issued under a redirect fetched the old path.
          r_busy[i]  <= 1'b1;
          r_ready[i] <= 1'b0;
          r_stale[i] <= D_br_val;
        end else if (r_busy[i]) begin
          if (w_dlv_oh[i]) begin
            r_busy[i] <= 1'b0;
          end else if (w_resp_oh[i] && (r_stale[i] || D_br_val)) begin
            // Response for a flushed fetch: its slot is done, data dropped.
            r_busy[i]  <= 1'b0;
            r_ready[i] <= 1'b0;
            r_stale[i] <= 1'b0;
          end else if (w_resp_oh[i]) begin
            r_ready[i] <= 1'b1;
          end else if (D_br_val) begin
            if (r_ready[i]) r_busy[i] <= 1'b0;
            else            r_stale[i] <= 1'b1;
          end
        end
      end

      r_tail <= w_tail_nxt;
      if (D_br_val)      r_head <= w_tail_nxt;
      else if (w_d_fire) r_head <= r_head + IW'(1);

      if (w_d_fire) r_seq <= r_seq + p_seq_bits'(1);

      if (D_br_val)        r_pc <= D_br_target;
      else if (w_req_fire) r_pc <= r_pc + PC_STEP;
    end
  end

  // Slot payload needs no reset; the flags above qualify it.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_slot_pc[r_tail] <= r_pc;
    if (w_resp_hit && r_busy[w_resp_idx] && !r_stale[w_resp_idx])
      r_slot_inst[w_resp_idx] <= mem_resp_data;
  end
endmodule

// File: tb/tb_fetch_ooo.sv
// Bench for fetch_ooo: randomized memory/decode behaviour checked against a
// program-order delivery model.
module tb_fetch_ooo;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_val, mem_req_rdy;
  logic [31:0] mem_req_addr;
  logic [7:0]  mem_req_opaque;
  logic        mem_resp_val, mem_resp_rdy;
  logic [7:0]  mem_resp_opaque;
  logic [31:0] mem_resp_data;
  logic        D_val, D_rdy;
  logic [31:0] D_inst, D_pc;
  logic [7:0]  D_seq_num;
  logic        D_br_val;
  logic [31:0] D_br_target;

  always #5 clk = ~clk;

  fetch_ooo #(
    .p_addr_bits(32), .p_rst_addr(32'h0), .p_inst_bits(32),
    .p_opaq_bits(8), .p_max_in_flight(N), .p_seq_bits(8)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_req_addr(mem_req_addr), .mem_req_opaque(mem_req_opaque),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .mem_resp_opaque(mem_resp_opaque), .mem_resp_data(mem_resp_data),
    .D_val(D_val), .D_rdy(D_rdy), .D_inst(D_inst), .D_pc(D_pc),
    .D_seq_num(D_seq_num), .D_br_val(D_br_val), .D_br_target(D_br_target)
  );

  typedef struct { logic [7:0] tag; logic [31:0] addr; } mreq_t;
  mreq_t mem_q[$];
  logic [31:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model: requests walk the PC stream, deliveries walk it in order,
  // a redirect restarts both at the target.
  logic [31:0] m_req_pc, m_exp_pc;
  logic [7:0]  m_exp_seq;
  int          m_req_n;

  bit          o_req_fire, o_d_fire, o_resp_fire, o_req_val, o_d_val;
  logic [31:0] o_req_addr, o_d_pc, o_d_inst, e_req_addr, e_d_pc, e_d_inst;
  logic [7:0]  o_req_tag, o_d_seq, e_req_tag, e_d_seq;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hdeadbeef ^ (a * 32'h0100_0193);
  endfunction

  function automatic int pick_tag();
    if (mem_q.size() == 0) return -1;
    return int'(mem_q[$urandom_range(0, mem_q.size() - 1)].tag);
  endfunction

  function automatic int oldest_tag();
    if (mem_q.size() == 0) return -1;
    return int'(mem_q[0].tag);
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    mem_req_rdy = 0; mem_resp_val = 0; mem_resp_opaque = 0; mem_resp_data = 0;
    D_rdy = 0; D_br_val = 0; D_br_target = 0;
    mem_q.delete(); exp_q.delete();
    m_req_pc = 32'h0; m_exp_pc = 32'h0; m_exp_seq = 8'h0; m_req_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: sample at negedge, drive inputs, update memory + model, pass posedge.
  task automatic tick(input bit req_rdy, input bit d_rdy, input int resp_tag,
                      input bit br, input logic [31:0] tgt);
    int k;
    @(negedge clk);
    o_req_val  = mem_req_val;
    o_req_fire = mem_req_val && req_rdy;
    o_req_addr = mem_req_addr;
    o_req_tag  = mem_req_opaque;
    o_d_val    = D_val;
    o_d_fire   = D_val && d_rdy;
    o_d_pc     = D_pc;
    o_d_inst   = D_inst;
    o_d_seq    = D_seq_num;
    e_req_addr = m_req_pc;
    e_req_tag  = 8'(m_req_n % N);
    e_d_pc     = m_exp_pc;
    e_d_inst   = mem_word(m_exp_pc);
    e_d_seq    = m_exp_seq;
    mem_req_rdy = req_rdy; D_rdy = d_rdy; D_br_val = br; D_br_target = tgt;
    mem_resp_val = 1'b0;
    o_resp_fire = 1'b0;
    k = -1;
    if (resp_tag >= 0)
      foreach (mem_q[i]) if (k < 0 && mem_q[i].tag == 8'(resp_tag)) k = i;
    if (k >= 0) begin
      mem_resp_val = 1'b1;
      mem_resp_opaque = mem_q[k].tag;
      mem_resp_data = mem_word(mem_q[k].addr);
      if (mem_resp_rdy) begin
        mem_q.delete(k);
        o_resp_fire = 1'b1;
      end
    end
    if (o_req_fire) mem_q.push_back('{o_req_tag, o_req_addr});
    if (o_req_fire) begin m_req_pc = m_req_pc + 32'd4; m_req_n++; end
    if (o_d_fire) begin m_exp_pc = m_exp_pc + 32'd4; m_exp_seq = m_exp_seq + 8'd1; end
    if (br) begin m_req_pc = tgt; m_exp_pc = tgt; end
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 3;
    if (mem_req_val !== 1'b0) begin errors++; $display("FAIL rst_req_val: got %b want 0", mem_req_val); end
    if (D_val !== 1'b0) begin errors++; $display("FAIL rst_d_val: got %b want 0", D_val); end
    if (mem_resp_rdy !== 1'b0) begin errors++; $display("FAIL rst_resp_rdy: got %b want 0", mem_resp_rdy); end
    reset_dut();
    #1;
    checks += 5;
    if (mem_req_val !== 1'b1) begin errors++; $display("FAIL rel_req_val: got %b want 1", mem_req_val); end
    if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL rel_req_addr: got %h want 0", mem_req_addr); end
    if (mem_req_opaque !== 8'h0) begin errors++; $display("FAIL rel_req_opq: got %h want 0", mem_req_opaque); end
    if (mem_resp_rdy !== 1'b1) begin errors++; $display("FAIL rel_resp_rdy: got %b want 1", mem_resp_rdy); end
    if (D_val !== 1'b0) begin errors++; $display("FAIL rel_d_val: got %b want 0", D_val); end
  endtask

  task automatic test_basic();
    int seen = 0;
    reset_dut();
    for (int c = 0; c < 12; c++) begin
      tick(1, 1, oldest_tag(), 0, 32'h0);
      if (o_req_fire) begin
        checks += 2;
        if (o_req_addr !== e_req_addr) begin errors++; $display("FAIL basic_req_addr: got %h want %h", o_req_addr, e_req_addr); end
        if (o_req_tag !== e_req_tag) begin errors++; $display("FAIL basic_req_tag: got %h want %h", o_req_tag, e_req_tag); end
      end
      if (o_d_fire) begin
        checks += 3;
        if (o_d_pc !== e_d_pc) begin errors++; $display("FAIL basic_d_pc: got %h want %h", o_d_pc, e_d_pc); end
        if (o_d_inst !== e_d_inst) begin errors++; $display("FAIL basic_d_inst: got %h want %h", o_d_inst, e_d_inst); end
        if (o_d_seq !== e_d_seq) begin errors++; $display("FAIL basic_d_seq: got %h want %h", o_d_seq, e_d_seq); end
        if (seen == 0) begin
          checks += 3;
          if (o_d_inst !== 32'hdeadbeef) begin errors++; $display("FAIL basic_first_inst: got %h want deadbeef", o_d_inst); end
          if (o_d_pc !== 32'h0) begin errors++; $display("FAIL basic_first_pc: got %h want 0", o_d_pc); end
          if (o_d_seq !== 8'h0) begin errors++; $display("FAIL basic_first_seq: got %h want 0", o_d_seq); end
        end else if (seen == 1) begin
          checks += 2;
          if (o_d_pc !== 32'h4) begin errors++; $display("FAIL basic_second_pc: got %h want 4", o_d_pc); end
          if (o_d_seq !== 8'h1) begin errors++; $display("FAIL basic_second_seq: got %h want 1", o_d_seq); end
        end
        seen++;
      end
    end
    checks++;
    if (seen != 10) begin errors++; $display("FAIL basic_throughput: got %0d want 10", seen); end
  endtask

  task automatic test_out_of_order();
    int fires = 0;
    int seen = 0;
    int order [4] = '{2, 0, 3, 1};
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      tick(1, 0, -1, 0, 32'h0);
      if (o_req_fire) begin
        fires++;
        checks += 2;
        if (o_req_addr !== e_req_addr) begin errors++; $display("FAIL ooo_req_addr: got %h want %h", o_req_addr, e_req_addr); end
        if (o_req_tag !== e_req_tag) begin errors++; $display("FAIL ooo_req_tag: got %h want %h", o_req_tag, e_req_tag); end
      end
    end
    checks++;
    if (fires != 4) begin errors++; $display("FAIL ooo_issue_count: got %0d want 4", fires); end
    for (int a = 0; a < 4; a++) exp_q.push_back(mem_word(32'(a * 4)));
    for (int c = 0; c < 7; c++) begin
      tick(0, 1, (c < 4) ? order[c] : -1, 0, 32'h0);
      if (o_d_fire) begin
        checks += 3;
        if (exp_q.size() == 0 || o_d_inst !== exp_q[0]) begin errors++; $display("FAIL ooo_d_inst: got %h want %h", o_d_inst, e_d_inst); end
        if (o_d_pc !== e_d_pc) begin errors++; $display("FAIL ooo_d_pc: got %h want %h", o_d_pc, e_d_pc); end
        if (o_d_seq !== 8'(seen)) begin errors++; $display("FAIL ooo_d_seq: got %h want %h", o_d_seq, 8'(seen)); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        seen++;
      end
    end
    checks++;
    if (seen != 4) begin errors++; $display("FAIL ooo_deliver_count: got %0d want 4", seen); end
  endtask

  task automatic test_full();
    int fires = 0;
    int seen = 0;
    reset_dut();
    for (int c = 0; c < 8; c++) begin
      tick(1, 0, -1, 0, 32'h0);
      if (o_req_fire) begin
        checks++;
        if (o_req_tag !== 8'(fires)) begin errors++; $display("FAIL full_tag: got %h want %h", o_req_tag, 8'(fires)); end
        fires++;
      end
    end
    checks += 2;
    if (fires != 4) begin errors++; $display("FAIL full_issue_count: got %0d want 4", fires); end
    if (o_req_val !== 1'b0) begin errors++; $display("FAIL full_req_val: got %b want 0", o_req_val); end
    for (int c = 0; c < 6; c++) begin
      tick(1, 0, (c < 4) ? c : -1, 0, 32'h0);
      checks++;
      if (o_req_fire) begin errors++; $display("FAIL full_no_issue: got fire at %h want none", o_req_addr); end
    end
    checks++;
    if (o_d_val !== 1'b1) begin errors++; $display("FAIL full_d_val: got %b want 1", o_d_val); end
    for (int c = 0; c < 10; c++) begin
      tick(1, 1, oldest_tag(), 0, 32'h0);
      if (o_req_fire) begin
        checks++;
        if (o_req_addr !== e_req_addr) begin errors++; $display("FAIL full_req_addr: got %h want %h", o_req_addr, e_req_addr); end
      end
      if (o_d_fire) begin
        seen++;
        checks += 2;
        if (o_d_pc !== e_d_pc) begin errors++; $display("FAIL full_d_pc: got %h want %h", o_d_pc, e_d_pc); end
        if (o_d_seq !== e_d_seq) begin errors++; $display("FAIL full_d_seq: got %h want %h", o_d_seq, e_d_seq); end
      end
    end
    checks++;
    if (seen < 4) begin errors++; $display("FAIL full_drain: got %0d want >=4", seen); end
  endtask

  task automatic test_redirect();
    int fires = 0;
    int seen = 0;
    reset_dut();
    for (int c = 0; c < 3; c++) tick(1, 0, -1, 0, 32'h0);
    tick(0, 0, -1, 1, 32'h100);
    for (int c = 0; c < 4; c++) begin
      tick(1, 1, -1, 0, 32'h0);
      if (o_req_fire) begin
        fires++;
        checks += 2;
        if (o_req_addr !== 32'h100) begin errors++; $display("FAIL redir_req_addr: got %h want 100", o_req_addr); end
        if (o_req_tag !== 8'h3) begin errors++; $display("FAIL redir_req_tag: got %h want 3", o_req_tag); end
      end
      if (o_d_fire) seen++;
    end
    checks += 2;
    if (fires != 1) begin errors++; $display("FAIL redir_stall: got %0d issues want 1", fires); end
    if (seen != 0) begin errors++; $display("FAIL redir_early_d: got %0d want 0", seen); end
    tick(1, 1, 0, 0, 32'h0);
    tick(1, 1, -1, 0, 32'h0);
    checks += 2;
    if (o_req_fire !== 1'b1) begin errors++; $display("FAIL redir_resume: got %b want 1", o_req_fire); end
    if (o_req_addr !== 32'h104) begin errors++; $display("FAIL redir_resume_addr: got %h want 104", o_req_addr); end
    for (int c = 0; c < 12; c++) begin
      tick(1, 1, oldest_tag(), 0, 32'h0);
      if (o_d_fire) begin
        checks += 3;
        if (o_d_pc !== e_d_pc) begin errors++; $display("FAIL redir_d_pc: got %h want %h", o_d_pc, e_d_pc); end
        if (o_d_inst !== e_d_inst) begin errors++; $display("FAIL redir_d_inst: got %h want %h", o_d_inst, e_d_inst); end
        if (o_d_seq !== e_d_seq) begin errors++; $display("FAIL redir_d_seq: got %h want %h", o_d_seq, e_d_seq); end
        if (seen == 0) begin
          checks += 2;
          if (o_d_pc !== 32'h100) begin errors++; $display("FAIL redir_first_pc: got %h want 100", o_d_pc); end
          if (o_d_seq !== 8'h0) begin errors++; $display("FAIL redir_first_seq: got %h want 0", o_d_seq); end
        end
        seen++;
      end
    end
    checks++;
    if (seen == 0) begin errors++; $display("FAIL redir_no_delivery: got 0 want >0"); end
  endtask

  task automatic test_simultaneous();
    int seen = 0;
    reset_dut();
    for (int c = 0; c < 3; c++) tick(1, 0, -1, 0, 32'h0);
    for (int c = 0; c < 3; c++) tick(0, 0, c, 0, 32'h0);
    tick(0, 1, -1, 0, 32'h0);
    tick(0, 1, -1, 0, 32'h0);
    tick(1, 1, -1, 1, 32'h200);
    checks += 5;
    if (o_d_fire !== 1'b1) begin errors++; $display("FAIL simul_d_fire: got %b want 1", o_d_fire); end
    if (o_d_pc !== 32'h8) begin errors++; $display("FAIL simul_d_pc: got %h want 8", o_d_pc); end
    if (o_d_seq !== 8'h2) begin errors++; $display("FAIL simul_d_seq: got %h want 2", o_d_seq); end
    if (o_req_fire !== 1'b1) begin errors++; $display("FAIL simul_req_fire: got %b want 1", o_req_fire); end
    if (o_req_addr !== 32'hc) begin errors++; $display("FAIL simul_req_addr: got %h want c", o_req_addr); end
    for (int c = 0; c < 20; c++) begin
      tick(1, 1, ($urandom_range(0, 1) != 0) ? pick_tag() : -1, 0, 32'h0);
      if (o_d_fire) begin
        checks += 3;
        if (o_d_pc !== e_d_pc) begin errors++; $display("FAIL simul_post_pc: got %h want %h", o_d_pc, e_d_pc); end
        if (o_d_inst !== e_d_inst) begin errors++; $display("FAIL simul_post_inst: got %h want %h", o_d_inst, e_d_inst); end
        if (o_d_seq !== e_d_seq) begin errors++; $display("FAIL simul_post_seq: got %h want %h", o_d_seq, e_d_seq); end
        if (seen == 0) begin
          checks += 2;
          if (o_d_pc !== 32'h200) begin errors++; $display("FAIL simul_first_pc: got %h want 200", o_d_pc); end
          if (o_d_seq !== 8'h3) begin errors++; $display("FAIL simul_first_seq: got %h want 3", o_d_seq); end
        end
        seen++;
      end
    end
    checks++;
    if (seen == 0) begin errors++; $display("FAIL simul_no_delivery: got 0 want >0"); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    reset_dut();
    tick(1, 0, -1, 0, 32'h0);
    tick(1, 0, -1, 0, 32'h0);
    tick(0, 0, 0, 0, 32'h0);
    @(negedge clk);
    checks++;
    if (D_val !== 1'b1) begin errors++; $display("FAIL mid_pre_d_val: got %b want 1", D_val); end
    rst = 1'b1;
    #1;
    checks += 2;
    if (mem_req_val !== 1'b0) begin errors++; $display("FAIL mid_req_val: got %b want 0", mem_req_val); end
    if (D_val !== 1'b0) begin errors++; $display("FAIL mid_d_val: got %b want 0", D_val); end
    reset_dut();
    #1;
    checks += 2;
    if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL mid_req_addr: got %h want 0", mem_req_addr); end
    if (mem_req_opaque !== 8'h0) begin errors++; $display("FAIL mid_req_opq: got %h want 0", mem_req_opaque); end
    for (int c = 0; c < 6; c++) begin
      tick(1, 1, oldest_tag(), 0, 32'h0);
      if (o_d_fire && seen == 0) begin
        checks += 2;
        if (o_d_seq !== 8'h0) begin errors++; $display("FAIL mid_seq_restart: got %h want 0", o_d_seq); end
        if (o_d_pc !== 32'h0) begin errors++; $display("FAIL mid_pc_restart: got %h want 0", o_d_pc); end
      end
      if (o_d_fire) seen++;
    end
    checks++;
    if (seen == 0) begin errors++; $display("FAIL mid_no_delivery: got 0 want >0"); end
  endtask

  task automatic test_random();
    int seen = 0;
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 1) != 0) ? pick_tag() : -1,
           $urandom_range(0, 29) == 0, 32'h1000 + 32'($urandom_range(0, 1023)) * 32'd4);
      if (o_req_fire) begin
        checks += 2;
        if (o_req_addr !== e_req_addr) begin errors++; $display("FAIL rand_req_addr: got %h want %h", o_req_addr, e_req_addr); end
        if (o_req_tag !== e_req_tag) begin errors++; $display("FAIL rand_req_tag: got %h want %h", o_req_tag, e_req_tag); end
      end
      if (o_d_fire) begin
        seen++;
        checks += 3;
        if (o_d_pc !== e_d_pc) begin errors++; $display("FAIL rand_d_pc: got %h want %h", o_d_pc, e_d_pc); end
        if (o_d_inst !== e_d_inst) begin errors++; $display("FAIL rand_d_inst: got %h want %h", o_d_inst, e_d_inst); end
        if (o_d_seq !== e_d_seq) begin errors++; $display("FAIL rand_d_seq: got %h want %h", o_d_seq, e_d_seq); end
      end
    end
    checks++;
    if (seen < 100) begin errors++; $display("FAIL rand_progress: got %0d want >=100", seen); end
  endtask

  initial begin
    mem_req_rdy = 0; mem_resp_val = 0; mem_resp_opaque = 0; mem_resp_data = 0;
    D_rdy = 0; D_br_val = 0; D_br_target = 0;
    test_reset();
    test_basic();
    test_out_of_order();
    test_full();
    test_redirect();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
